// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response plus decoder handoff.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface fetch_unit_if;
    localparam int unsigned XLEN = 16;

    logic [XLEN-1:0] imemAddr;
    logic            imemReq;
    logic            imemAck;
    logic [XLEN-1:0] imemData;
    logic [XLEN-1:0] instruction;
    logic            instrValid;
    logic            decodeReady;
    logic [1:0]      nextPCSel;
    logic [XLEN-1:0] branchTarget;
    logic [XLEN-1:0] regTarget;

    modport master (
        output imemAddr, imemReq, instruction, instrValid,
        input  imemAck, imemData, decodeReady, nextPCSel, branchTarget, regTarget
    );

    modport slave (
        input  imemAddr, imemReq, instruction, instrValid,
        output imemAck, imemData, decodeReady, nextPCSel, branchTarget, regTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding imem request at a time,
// registers the returned word for the decoder and steers the PC on decoder acceptance.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output logic [15:0]  pc,
    output logic [15:0]  retireCount
);
    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   retire_q, retire_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   next_pc_c;

    // Branch/target select; only consumed on the DECODE accept edge.
    always_comb begin
        next_pc_c = pc_q + XLEN'(1);
        case (bus.nextPCSel)
            2'b01:   next_pc_c = bus.branchTarget;
            2'b10:   next_pc_c = bus.regTarget;
            default: next_pc_c = pc_q + XLEN'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    // Request/valid flags are registered copies of the upcoming state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imemAck) begin
                    instr_d = bus.imemData;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.decodeReady) begin
                    pc_d     = next_pc_c;
                    retire_d = retire_q + XLEN'(1);
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_DECODE);
    end

    assign bus.imemAddr    = pc_q;
    assign bus.imemReq     = req_q;
    assign bus.instruction = instr_q;
    assign bus.instrValid  = valid_q;
    assign pc              = pc_q;
    assign retireCount     = retire_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner cases,
// then randomized transactions against an instruction-level reference model.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] retireCount;

    int errors = 0;
    int checks = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pc          (pc),
        .retireCount (retireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] bt;
        logic [15:0] rt;
        int          ack_delay;
        int          stall;
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
        logic [15:0] exp_next;
    } vec_t;

    // Instruction memory contents seen by the bench.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'hA105;
            16'h0001: mem_word = 16'hA203;
            16'h0002: mem_word = 16'h0040;
            default:  mem_word = a ^ 16'h8000;
        endcase
    endfunction

    // Reference next-PC rule.
    function automatic logic [15:0] ref_next(input logic [15:0] cur, input logic [1:0] sel,
                                             input logic [15:0] bt, input logic [15:0] rt);
        if (sel == 2'b01)      ref_next = bt;
        else if (sel == 2'b10) ref_next = rt;
        else                   ref_next = 16'((32'(cur) + 1) % 65536);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic scramble_decoder();
        bus.nextPCSel    = 2'($urandom);
        bus.branchTarget = 16'($urandom);
        bus.regTarget    = 16'($urandom);
        bus.decodeReady  = 1'($urandom);
    endtask

    // One full instruction: fetch (with ack delay), hold in decode (with stall), accept.
    task automatic run_instr(input logic [1:0] sel, input logic [15:0] bt, input logic [15:0] rt,
                             input int ack_delay, input int stall,
                             input logic [15:0] exp_addr, input logic [15:0] exp_instr,
                             input logic [15:0] exp_next, input logic [15:0] exp_retire);
        int n;
        logic [15:0] prev_retire;
        n = 0;
        while (!bus.imemReq && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req_latency", 32'(n), 32'd0);
        chk("fetch_addr", 32'(bus.imemAddr), 32'(exp_addr));
        prev_retire = retireCount;
        for (int i = 0; i < ack_delay; i++) begin
            bus.imemAck  = 1'b0;
            bus.imemData = 16'($urandom);
            scramble_decoder();
            @(negedge clk);
            chk("wait_req", 32'(bus.imemReq), 32'd1);
            chk("wait_addr", 32'(bus.imemAddr), 32'(exp_addr));
            chk("wait_valid", 32'(bus.instrValid), 32'd0);
        end
        bus.imemAck  = 1'b1;
        bus.imemData = mem_word(bus.imemAddr);
        scramble_decoder();
        @(negedge clk);
        bus.imemAck  = 1'b0;
        bus.imemData = 16'($urandom);
        chk("valid_after_ack", 32'(bus.instrValid), 32'd1);
        chk("instruction", 32'(bus.instruction), 32'(exp_instr));
        chk("req_drop", 32'(bus.imemReq), 32'd0);
        chk("decode_pc", 32'(pc), 32'(exp_addr));
        for (int i = 0; i < stall; i++) begin
            bus.decodeReady  = 1'b0;
            bus.imemAck      = 1'($urandom);
            bus.imemData     = 16'($urandom);
            bus.nextPCSel    = 2'($urandom);
            bus.branchTarget = 16'($urandom);
            bus.regTarget    = 16'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(bus.instrValid), 32'd1);
            chk("stall_instr", 32'(bus.instruction), 32'(exp_instr));
            chk("stall_pc", 32'(pc), 32'(exp_addr));
            chk("stall_req", 32'(bus.imemReq), 32'd0);
            chk("stall_retire", 32'(retireCount), 32'(prev_retire));
        end
        bus.decodeReady  = 1'b1;
        bus.nextPCSel    = sel;
        bus.branchTarget = bt;
        bus.regTarget    = rt;
        @(negedge clk);
        bus.imemAck      = 1'b0;
        bus.decodeReady  = 1'b0;
        bus.nextPCSel    = 2'($urandom);
        chk("next_req", 32'(bus.imemReq), 32'd1);
        chk("next_addr", 32'(bus.imemAddr), 32'(exp_next));
        chk("next_valid", 32'(bus.instrValid), 32'd0);
        chk("retire", 32'(retireCount), 32'(exp_retire));
    endtask

    vec_t vecs[13];
    logic [15:0] m_pc;
    logic [15:0] m_retire;

    initial begin
        vecs[0]  = '{2'b00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'hA105, 16'h0001};
        vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 3, 0, 16'h0001, 16'hA203, 16'h0002};
        vecs[2]  = '{2'b00, 16'h0000, 16'h0000, 0, 4, 16'h0002, 16'h0040, 16'h0003};
        vecs[3]  = '{2'b01, 16'h0004, 16'h0000, 0, 0, 16'h0003, 16'h8003, 16'h0004};
        vecs[4]  = '{2'b01, 16'h0020, 16'h5555, 0, 0, 16'h0004, 16'h8004, 16'h0020};
        vecs[5]  = '{2'b10, 16'h00AA, 16'h0004, 1, 0, 16'h0020, 16'h8020, 16'h0004};
        vecs[6]  = '{2'b10, 16'h00AA, 16'h1234, 0, 0, 16'h0004, 16'h8004, 16'h1234};
        vecs[7]  = '{2'b11, 16'h0077, 16'h9999, 0, 2, 16'h1234, 16'h9234, 16'h1235};
        vecs[8]  = '{2'b01, 16'h0004, 16'h0000, 0, 0, 16'h1235, 16'h9235, 16'h0004};
        vecs[9]  = '{2'b11, 16'h0020, 16'h1234, 0, 0, 16'h0004, 16'h8004, 16'h0005};
        vecs[10] = '{2'b10, 16'h0000, 16'hFFFF, 0, 0, 16'h0005, 16'h8005, 16'hFFFF};
        vecs[11] = '{2'b00, 16'h0000, 16'h0000, 2, 1, 16'hFFFF, 16'h7FFF, 16'h0000};
        vecs[12] = '{2'b00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'hA105, 16'h0001};

        rst_n            = 1'b0;
        bus.imemAck      = 1'b0;
        bus.imemData     = 16'h0000;
        bus.decodeReady  = 1'b0;
        bus.nextPCSel    = 2'b00;
        bus.branchTarget = 16'h0000;
        bus.regTarget    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.imemReq), 32'd0);
        chk("rst_valid", 32'(bus.instrValid), 32'd0);
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_instr", 32'(bus.instruction), 32'h0000);
        chk("rst_retire", 32'(retireCount), 32'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].sel, vecs[i].bt, vecs[i].rt, vecs[i].ack_delay, vecs[i].stall,
                      vecs[i].exp_addr, vecs[i].exp_instr, vecs[i].exp_next, 16'(i + 1));
        end

        // Reset while a fetch is outstanding, with the ack landing in the reset cycle.
        bus.imemAck = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", 32'(bus.imemReq), 32'd1);
        rst_n        = 1'b0;
        bus.imemAck  = 1'b1;
        bus.imemData = 16'hBEEF;
        @(negedge clk);
        chk("midrst_req", 32'(bus.imemReq), 32'd0);
        chk("midrst_valid", 32'(bus.instrValid), 32'd0);
        chk("midrst_pc", 32'(pc), 32'h0000);
        chk("midrst_instr", 32'(bus.instruction), 32'h0000);
        chk("midrst_retire", 32'(retireCount), 32'h0000);
        // Late ack while in RST must be dropped.
        rst_n = 1'b1;
        @(negedge clk);
        bus.imemAck = 1'b0;
        chk("late_ack_instr", 32'(bus.instruction), 32'h0000);
        chk("late_ack_valid", 32'(bus.instrValid), 32'd0);
        chk("restart_req", 32'(bus.imemReq), 32'd1);
        chk("restart_addr", 32'(bus.imemAddr), 32'h0000);

        // Randomized transactions against the instruction-level model.
        m_pc     = 16'h0000;
        m_retire = 16'h0000;
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  sel;
            logic [15:0] bt;
            logic [15:0] rt;
            logic [15:0] nxt;
            sel = 2'($urandom);
            bt  = {8'h00, 8'($urandom)};
            rt  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rt = 16'hFFFF;
            nxt = ref_next(m_pc, sel, bt, rt);
            m_retire = 16'((32'(m_retire) + 1) % 65536);
            run_instr(sel, bt, rt, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      m_pc, mem_word(m_pc), nxt, m_retire);
            m_pc = nxt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
